clk_div_meter: RTL and testbench

- Measures a slow, clock-like input in the fast `clk` domain and reports its high and low half-periods in `clk` cycles.
- Also reports the equivalent divider prescaler, a symmetry flag and a stall flag.
- Acts as the receive side of the team's clock dividers: it checks divided clocks, reference ticks and external slow clocks at runtime.
- Sits beside clock generation as a monitor and never drives a clock.

---
 rtl/clk_div_meter.sv | 142 ++++++++++++++
 tb/tb_clk_div_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_meter.sv
// Half-period meter for a slow clock-like input sampled in the clk domain.
// Reports high/low lengths, the matching divider prescaler, symmetry and stall status.
module clk_div_meter #(
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_in,
    input  logic                   en,
    output logic [COUNT_WIDTH-1:0] high_cycles,
    output logic [COUNT_WIDTH-1:0] low_cycles,
    output logic [COUNT_WIDTH-1:0] prescaler_est,
    output logic                   symmetric,
    output logic                   meas_valid,
    output logic                   stalled
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;
    logic                   rise;
    logic                   fall;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] high_len_q, high_len_d;
    logic [COUNT_WIDTH-1:0] high_d, low_d, presc_d;
    logic                   sym_d, valid_d, stalled_d;

    // Input synchronizer plus one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;
    assign fall   = ~synced & prev_q;

    // State, counter and registered measurement outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARM;
            cnt_q         <= '0;
            high_len_q    <= '0;
            high_cycles   <= '0;
            low_cycles    <= '0;
            prescaler_est <= '0;
            symmetric     <= 1'b0;
            meas_valid    <= 1'b0;
            stalled       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_len_q    <= high_len_d;
            high_cycles   <= high_d;
            low_cycles    <= low_d;
            prescaler_est <= presc_d;
            symmetric     <= sym_d;
            meas_valid    <= valid_d;
            stalled       <= stalled_d;
        end
    end

    // Next-state and output logic; an edge coinciding with a full counter wins over stall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_len_d = high_len_q;
        high_d     = high_cycles;
        low_d      = low_cycles;
        presc_d    = prescaler_est;
        sym_d      = symmetric;
        valid_d    = 1'b0;
        stalled_d  = stalled;

        if (!en) begin
            state_d = ARM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        high_len_d = cnt_q;
                        cnt_d      = CNT_ONE;
                        state_d    = LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        stalled_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_d    = high_len_q;
                        low_d     = cnt_q;
                        presc_d   = high_len_q - CNT_ONE;
                        sym_d     = (high_len_q == cnt_q);
                        valid_d   = 1'b1;
                        stalled_d = 1'b0;
                        cnt_d     = CNT_ONE;
                        state_d   = HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        stalled_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_meter.sv
// Randomized bench for clk_div_meter against an edge-timestamp reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_clk_div_meter;

    localparam int unsigned W    = 4;
    localparam int unsigned S    = 2;
    localparam int          MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_in;
    logic         en;
    logic [W-1:0] high_cycles;
    logic [W-1:0] low_cycles;
    logic [W-1:0] prescaler_est;
    logic         symmetric;
    logic         meas_valid;
    logic         stalled;

    always #5 clk = ~clk;

    clk_div_meter #(
        .COUNT_WIDTH(W),
        .SYNC_STAGES(S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .en           (en),
        .high_cycles  (high_cycles),
        .low_cycles   (low_cycles),
        .prescaler_est(prescaler_est),
        .symmetric    (symmetric),
        .meas_valid   (meas_valid),
        .stalled      (stalled)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: input history, edge timestamps and expected outputs
    logic hist [S+2];
    int   t = 0;
    bit   armed, have_fall;
    int   t_rise, t_fall, t_edge;
    int   e_hi, e_lo, e_pre;
    bit   e_sym, e_valid, e_stall;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(S) + 2; i++) hist[i] = 1'b0;
        armed     = 1'b0;
        have_fall = 1'b0;
        t_rise    = 0;
        t_fall    = 0;
        t_edge    = 0;
        e_hi      = 0;
        e_lo      = 0;
        e_pre     = 0;
        e_sym     = 1'b0;
        e_valid   = 1'b0;
        e_stall   = 1'b0;
    endtask

    // The DUT sees each input sample S cycles late; edges are timestamped in decision cycles
    task automatic model_step(input logic x, input logic e);
        bit r, f;
        for (int i = int'(S) + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        t++;
        e_valid = 1'b0;
        r = hist[S] && !hist[S+1];
        f = !hist[S] && hist[S+1];
        if (!e) begin
            armed = 1'b0;
        end else if (!armed) begin
            if (r) begin
                armed     = 1'b1;
                have_fall = 1'b0;
                t_rise    = t;
                t_edge    = t;
            end
        end else if (r && have_fall) begin
            e_hi      = t_fall - t_rise;
            e_lo      = t - t_fall;
            e_pre     = (e_hi - 1) & MAXC;
            e_sym     = (e_hi == e_lo);
            e_valid   = 1'b1;
            e_stall   = 1'b0;
            t_rise    = t;
            t_edge    = t;
            have_fall = 1'b0;
        end else if (f && !have_fall) begin
            t_fall    = t;
            t_edge    = t;
            have_fall = 1'b1;
        end else if (t - t_edge >= MAXC) begin
            e_stall = 1'b1;
            armed   = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("meas_valid", int'(meas_valid), int'(e_valid));
        check("stalled", int'(stalled), int'(e_stall));
        check("high_cycles", int'(high_cycles), e_hi);
        check("low_cycles", int'(low_cycles), e_lo);
        check("prescaler_est", int'(prescaler_est), e_pre);
        check("symmetric", int'(symmetric), int'(e_sym));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high"}, int'(high_cycles), 0);
        check({tag, "_low"}, int'(low_cycles), 0);
        check({tag, "_presc"}, int'(prescaler_est), 0);
        check({tag, "_sym"}, int'(symmetric), 0);
        check({tag, "_valid"}, int'(meas_valid), 0);
        check({tag, "_stalled"}, int'(stalled), 0);
    endtask

    task automatic tick(input logic x, input logic e, input logic r);
        @(negedge clk);
        compare_all();
        clk_in = x;
        en     = e;
        rst_n  = r;
        if (!r) begin
            #1;
            check_zero("async_rst");
            model_reset();
        end else begin
            model_step(x, e);
        end
    endtask

    // Periodic waveform; en is dropped for drop_len ticks starting at tick drop_at
    task automatic wave(input int hi, input int lo, input int periods,
                        input int drop_at, input int drop_len);
        int k = 0;
        for (int p = 0; p < periods; p++) begin
            for (int c = 0; c < hi + lo; c++) begin
                tick(logic'(c < hi), logic'(!(k >= drop_at && k < drop_at + drop_len)), 1'b1);
                k++;
            end
        end
    endtask

    task automatic expect_meas(input string tag, input int hi, input int lo, input int sym);
        check({tag, "_high"}, int'(high_cycles), hi);
        check({tag, "_low"}, int'(low_cycles), lo);
        check({tag, "_presc"}, int'(prescaler_est), hi - 1);
        check({tag, "_sym"}, int'(symmetric), sym);
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_in = 1'b0;
        en     = 1'b0;
        model_reset();
        #1;
        check_zero("reset");

        repeat (3) tick(1'b0, 1'b1, 1'b1);

        wave(4, 4, 5, -1, 0);
        expect_meas("div_p3", 4, 4, 1);
        check("div_p3_stalled", int'(stalled), 0);

        wave(1, 1, 8, -1, 0);
        expect_meas("div_p0", 1, 1, 1);

        wave(3, 7, 4, -1, 0);
        expect_meas("asym", 3, 7, 0);

        // Stuck high after one rise
        repeat (24) tick(1'b1, 1'b1, 1'b1);
        check("stall_flag", int'(stalled), 1);
        expect_meas("stall_hold", 3, 7, 0);

        wave(2, 2, 4, -1, 0);
        check("stall_clear", int'(stalled), 0);
        expect_meas("resume", 2, 2, 1);

        // en dropped for 5 cycles in the middle of a low phase
        wave(5, 5, 3, -1, 0);
        repeat (2) tick(1'b0, 1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b1, 1'b1);
        wave(6, 3, 1, -1, 0);
        expect_meas("en_hold", 5, 5, 1);
        wave(6, 3, 2, -1, 0);
        expect_meas("en_resume", 6, 3, 0);

        // Reset asserted in the middle of a high phase
        wave(4, 4, 2, -1, 0);
        repeat (2) tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        wave(3, 5, 3, -1, 0);
        expect_meas("post_rst", 3, 5, 0);

        repeat (40) begin
            int hi, lo, np, da, dl;
            hi = int'($urandom_range(15, 1));
            lo = int'($urandom_range(15, 1));
            np = int'($urandom_range(4, 1));
            da = ($urandom_range(7, 0) == 0) ? int'($urandom_range(20, 0)) : -1;
            dl = (da >= 0) ? int'($urandom_range(6, 1)) : 0;
            wave(hi, lo, np, da, dl);
            if ($urandom_range(9, 0) == 0)
                repeat (int'($urandom_range(20, 16))) tick(clk_in, 1'b1, 1'b1);
        end

        repeat (6) tick(clk_in, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
